cam: RTL and testbench



---
 rtl/cam_pkg.sv | 12 +
 rtl/cam_if.sv | 34 +++
 rtl/cam_prio_enc.sv | 20 ++
 rtl/cam.sv | 93 +++++++++
 tb/tb_cam.sv | 141 ++++++++++++++
 5 files changed

// File: rtl/cam_pkg.sv
// cam_pkg: geometry constants and shared types for the CAM.
// Optional macro CAM_WRITE_BYPASS_EN is consumed by cam.sv.
package cam_pkg;

    localparam int ENTRIES = 32;
    localparam int WIDTH   = 32;
    localparam int IDX_W   = $clog2(ENTRIES);

    typedef logic [IDX_W-1:0] cam_idx_t;
    typedef logic [WIDTH-1:0] cam_data_t;

endpackage

// File: rtl/cam_if.sv
// cam_ifc: request strobes and registered results of the CAM.
// dut modport faces the CAM, bench modport faces the host/bench.
interface cam_ifc;
    import cam_pkg::*;

    logic      read_i;
    cam_idx_t  read_index_i;
    logic      write_i;
    cam_idx_t  write_index_i;
    cam_data_t write_data_i;
    logic      search_i;
    cam_data_t search_data_i;
    logic      read_valid_o;
    cam_data_t read_value_o;
    logic      search_valid_o;
    cam_idx_t  search_index_o;

    modport dut (
        input  read_i, read_index_i,
        input  write_i, write_index_i, write_data_i,
        input  search_i, search_data_i,
        output read_valid_o, read_value_o,
        output search_valid_o, search_index_o
    );

    modport bench (
        output read_i, read_index_i,
        output write_i, write_index_i, write_data_i,
        output search_i, search_data_i,
        input  read_valid_o, read_value_o,
        input  search_valid_o, search_index_o
    );

endinterface

// File: rtl/cam_prio_enc.sv
// cam_prio_enc: match vector to found flag plus lowest set index.
module cam_prio_enc #(
    parameter int N  = 32,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  vec,
    output logic          found,
    output logic [IW-1:0] idx
);

    always_comb begin
        found = |vec;
        idx   = '0;
        // Scan downward so the lowest set bit wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) idx = IW'(i);
        end
    end

endmodule

// File: rtl/cam.sv
// cam: 32x32 content-addressable memory, 1-cycle read/write/search.
// Define CAM_WRITE_BYPASS_EN to let same-cycle reads/searches see the write.
module cam
    import cam_pkg::*;
(
    input logic   clk,
    input logic   reset,
    cam_ifc.dut   bus
);

    cam_data_t          data [ENTRIES];
    logic [ENTRIES-1:0] valid;

    cam_data_t          eff_data [ENTRIES];
    logic [ENTRIES-1:0] eff_valid;
    logic [ENTRIES-1:0] match;

    logic      rd_hit;
    cam_data_t rd_value;
    logic      found;
    cam_idx_t  found_idx;

    logic      read_valid_q;
    cam_data_t read_value_q;
    logic      search_valid_q;
    cam_idx_t  search_index_q;

    // Contents seen by this cycle's read and search.
    always_comb begin
        eff_valid = valid;
        for (int i = 0; i < ENTRIES; i++) begin
            eff_data[i] = data[i];
        end
`ifdef CAM_WRITE_BYPASS_EN
        if (bus.write_i) begin
            eff_valid[bus.write_index_i] = 1'b1;
            eff_data[bus.write_index_i]  = bus.write_data_i;
        end
`endif
    end

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            match[i] = bus.search_i && eff_valid[i]
                    && (eff_data[i] == bus.search_data_i);
        end
    end

    always_comb begin
        rd_hit   = bus.read_i && eff_valid[bus.read_index_i];
        rd_value = rd_hit ? eff_data[bus.read_index_i] : '0;
    end

    cam_prio_enc #(
        .N  (ENTRIES),
        .IW (IDX_W)
    ) u_prio (
        .vec   (match),
        .found (found),
        .idx   (found_idx)
    );

    // Data needs no reset; valid gates every use of it.
    always_ff @(posedge clk) begin
        if (!reset && bus.write_i) begin
            data[bus.write_index_i] <= bus.write_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid          <= '0;
            read_valid_q   <= 1'b0;
            read_value_q   <= '0;
            search_valid_q <= 1'b0;
            search_index_q <= '0;
        end else begin
            if (bus.write_i) begin
                valid[bus.write_index_i] <= 1'b1;
            end
            read_valid_q   <= rd_hit;
            read_value_q   <= rd_value;
            search_valid_q <= found;
            search_index_q <= found ? found_idx : '0;
        end
    end

    assign bus.read_valid_o   = read_valid_q;
    assign bus.read_value_o   = read_value_q;
    assign bus.search_valid_o = search_valid_q;
    assign bus.search_index_o = search_index_q;

endmodule

// File: tb/tb_cam.sv
// tb_cam: table-driven vectors plus reset corner sequences for cam.
// Expected results are queued at drive time and popped after the edge.
module tb_cam;
    import cam_pkg::*;

    typedef struct packed {
        logic      rst;
        logic      rd;
        cam_idx_t  ridx;
        logic      wr;
        cam_idx_t  widx;
        cam_data_t wdata;
        logic      sr;
        cam_data_t skey;
        logic      e_rv;
        cam_data_t e_rval;
        logic      e_sv;
        cam_idx_t  e_sidx;
    } vec_t;

    typedef struct packed {
        logic      rv;
        cam_data_t rval;
        logic      sv;
        cam_idx_t  sidx;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    cam_ifc bus ();

    cam dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(
        logic rst, logic rd, int ridx, logic wr, int widx,
        logic [31:0] wdata, logic sr, logic [31:0] skey,
        logic e_rv, logic [31:0] e_rval, logic e_sv, int e_sidx
    );
        vec_t v;
        v.rst = rst;   v.rd = rd;     v.ridx = cam_idx_t'(ridx);
        v.wr = wr;     v.widx = cam_idx_t'(widx);
        v.wdata = wdata; v.sr = sr;   v.skey = skey;
        v.e_rv = e_rv; v.e_rval = e_rval; v.e_sv = e_sv;
        v.e_sidx = cam_idx_t'(e_sidx);
        return v;
    endfunction

    task automatic apply(input vec_t v, input string name);
        exp_t e;
        exp_t got;
        reset             = v.rst;
        bus.read_i        = v.rd;
        bus.read_index_i  = v.ridx;
        bus.write_i       = v.wr;
        bus.write_index_i = v.widx;
        bus.write_data_i  = v.wdata;
        bus.search_i      = v.sr;
        bus.search_data_i = v.skey;
        sb.push_back({v.e_rv, v.e_rval, v.e_sv, v.e_sidx});
        @(posedge clk);
        #1;
        reset      = 1'b0;
        bus.read_i = 1'b0; bus.write_i = 1'b0; bus.search_i = 1'b0;
        got = {bus.read_valid_o, bus.read_value_o,
               bus.search_valid_o, bus.search_index_o};
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            if (got !== e) begin
                failures++;
                $display("FAIL %s: got rv=%0b val=%h sv=%0b idx=%0d want rv=%0b val=%h sv=%0b idx=%0d",
                         name, got.rv, got.rval, got.sv, got.sidx,
                         e.rv, e.rval, e.sv, e.sidx);
            end
        end
    endtask

    vec_t tbl[$];

    initial begin
        bus.read_i = 0; bus.read_index_i = '0;
        bus.write_i = 0; bus.write_index_i = '0; bus.write_data_i = '0;
        bus.search_i = 0; bus.search_data_i = '0;

        apply(mk(1,0,0,0,0,0,0,0, 0,0,0,0), "reset");
        apply(mk(1,0,0,0,0,0,0,0, 0,0,0,0), "reset2");

        tbl.push_back(mk(0,1,7,0,0,0,1,32'h0,             0,0,0,0));
        tbl.push_back(mk(0,0,0,1,3,32'hDEADBEEF,0,0,      0,0,0,0));
        tbl.push_back(mk(0,1,3,0,0,0,0,0,                 1,32'hDEADBEEF,0,0));
        tbl.push_back(mk(0,0,0,1,9,32'h1234,0,0,          0,0,0,0));
        tbl.push_back(mk(0,0,0,1,4,32'h1234,0,0,          0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,1,32'h1234,          0,0,1,4));
        tbl.push_back(mk(0,0,0,1,4,32'h5555,0,0,          0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,1,32'h1234,          0,0,1,9));
        tbl.push_back(mk(0,0,0,0,0,0,1,32'hAAAA,          0,0,0,0));
`ifdef CAM_WRITE_BYPASS_EN
        tbl.push_back(mk(0,1,0,1,0,32'h77,1,32'h77,       1,32'h77,1,0));
`else
        tbl.push_back(mk(0,1,0,1,0,32'h77,1,32'h77,       0,0,0,0));
`endif
        tbl.push_back(mk(0,1,0,0,0,0,1,32'h77,            1,32'h77,1,0));
        tbl.push_back(mk(0,1,31,0,0,0,1,32'hDEADBEEF,     0,0,1,3));
        tbl.push_back(mk(0,0,0,1,5,32'hDEADBEEF,1,32'hDEADBEEF, 0,0,1,3));
        tbl.push_back(mk(0,1,9,0,0,0,1,32'h5555,          1,32'h1234,1,4));
        tbl.push_back(mk(0,0,0,1,31,32'hFFFFFFFF,0,0,     0,0,0,0));
        tbl.push_back(mk(0,1,31,0,0,0,1,32'hFFFFFFFF,     1,32'hFFFFFFFF,1,31));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,                 0,0,0,0));

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // Fill every entry, then reset together with a write.
        for (int i = 0; i < ENTRIES; i++)
            apply(mk(0,0,0,1,i,32'h1000 + i,0,0, 0,0,0,0), $sformatf("fill%0d", i));
        apply(mk(0,1,10,0,0,0,1,32'h100A, 1,32'h100A,1,10), "full_hit");
        apply(mk(0,1,0,0,0,0,1,32'h1000,  1,32'h1000,1,0), "full_low");
        apply(mk(1,1,2,1,2,32'h9999,1,32'h1002, 0,0,0,0), "rst_drop");
        for (int i = 0; i < ENTRIES; i++)
            apply(mk(0,1,i,0,0,0,1,32'h1000 + i, 0,0,0,0), $sformatf("post_rst%0d", i));
        apply(mk(0,1,2,0,0,0,1,32'h9999, 0,0,0,0), "dropped_wr");
        apply(mk(0,0,0,1,2,32'hABC,0,0,    0,0,0,0), "wr_after");
        apply(mk(0,1,2,0,0,0,1,32'hABC,    1,32'hABC,1,2), "rd_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
